// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter in front of a single fixed-latency memory
//   clk, rst                  : clock, asynchronous active-high reset
//   mN_req/we/addr/wdata      : requester N access request, direction, byte address, write data
//   mN_gnt                    : one-cycle pulse when requester N's access is issued to memory
//   mN_rvalid, rdata          : one-cycle read-return pulse for requester N, shared read data
//   mem_en/we/addr/wdata      : memory strobe, write enable, address, write data
//   mem_rdata                 : memory read data, valid RD_LAT cycles after mem_en
//   busy                      : an access is in flight
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);
  state_t        r_state;
  state_t        w_next;
  // r_owner is both the current owner and the last-grant record (1 = m1)
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_cnt;
  logic          w_any;
  logic          w_win;
  logic          w_access;
  logic          w_rvalid;
  assign w_any = m0_req | m1_req;
  // on a tie the port that did not win last time takes the memory
  assign w_win = (m0_req & m1_req) ? ~r_owner : m1_req;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_win;
        r_we    <= w_win ? m1_we : m0_we;
        r_addr  <= w_win ? m1_addr : m0_addr;
        r_wdata <= w_win ? m1_wdata : m0_wdata;
      end
      r_cnt <= (r_state == ACCESS) ? LAT_M1 :
               (r_state == WAIT && r_cnt != 2'd0) ? r_cnt - 2'd1 : r_cnt;
    end
  end
  always_comb begin
    w_next   = r_state;
    w_access = r_state == ACCESS;
    w_rvalid = r_state == WAIT && r_cnt == 2'd0;
    case (r_state)
      IDLE:    w_next = w_any ? ACCESS : IDLE;
      ACCESS:  w_next = r_we ? IDLE : WAIT;
      WAIT:    w_next = w_rvalid ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  assign mem_en    = w_access;
  assign mem_we    = w_access & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign m0_gnt    = w_access & ~r_owner;
  assign m1_gnt    = w_access & r_owner;
  assign m0_rvalid = w_rvalid & ~r_owner;
  assign m1_rvalid = w_rvalid & r_owner;
  assign rdata     = w_rvalid ? mem_rdata : '0;
  assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter at RD_LAT=1 and RD_LAT=3
module tb_mem_port_arbiter;
  localparam int L = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        m0_req3 = 0, m0_we3 = 0, m1_req3 = 0, m1_we3 = 0;
  logic [31:0] m0_addr3 = 0, m0_wdata3 = 0, m1_addr3 = 0, m1_wdata3 = 0;
  logic        m0_gnt3, m1_gnt3, m0_rvalid3, m1_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] rdata3, mem_addr3, mem_wdata3;
  logic [31:0] mem_rdata3 = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(L)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req3), .m0_we(m0_we3), .m0_addr(m0_addr3), .m0_wdata(m0_wdata3),
    .m1_req(m1_req3), .m1_we(m1_we3), .m1_addr(m1_addr3), .m1_wdata(m1_wdata3),
    .m0_gnt(m0_gnt3), .m1_gnt(m1_gnt3), .m0_rvalid(m0_rvalid3), .m1_rvalid(m1_rvalid3),
    .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3));

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A5A5A5A;
  endfunction

  // memory behind u1: one-cycle read latency, reinitialised on reset
  logic [31:0] dmem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= dmem[mem_addr[7:0]];
    end
  end
  // u3 memory output changes every cycle so a registered rdata path would show
  always @(posedge clk) mem_rdata3 <= mem_rdata3 + 32'h01000003;

  // reference model: access timeline in cycle numbers
  int          total = 0, bad = 0;
  int          cyc = 0, acc, idle_from;
  int          wt [2];
  logic        own, rd, last;
  logic [31:0] m_addr, m_wdata, exp_rd;
  logic [31:0] mmem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    acc = -100; idle_from = 0; last = 1'b1; own = 1'b0; rd = 1'b0;
    m_addr = 0; m_wdata = 0; exp_rd = 0; wt[0] = 0; wt[1] = 0;
    for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
  endtask

  task automatic check();
    logic a, v;
    a = !rst && cyc == acc;
    v = !rst && rd && cyc == acc + L;
    chk1("m0_gnt", m0_gnt, a && !own);
    chk1("m1_gnt", m1_gnt, a && own);
    chk1("m0_rvalid", m0_rvalid, v && !own);
    chk1("m1_rvalid", m1_rvalid, v && own);
    chk("rdata", rdata, v ? exp_rd : 32'h0);
    chk1("mem_en", mem_en, a);
    chk1("mem_we", mem_we, a && !rd);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk1("busy", busy, !rst && cyc < idle_from);
    chk1("one_gnt", m0_gnt & m1_gnt, 1'b0);
    chk1("one_rvalid", m0_rvalid & m1_rvalid, 1'b0);
    if (!rst && m0_req) begin
      if (m0_gnt) begin chk1("m0_wait", wt[0] <= 2 * (L + 2), 1'b1); wt[0] = 0; end
      else wt[0]++;
    end
    if (!rst && m1_req) begin
      if (m1_gnt) begin chk1("m1_wait", wt[1] <= 2 * (L + 2), 1'b1); wt[1] = 0; end
      else wt[1]++;
    end
  endtask

  // schedule an access from the inputs of this cycle, advance one cycle, check
  task automatic tick();
    logic w;
    if (!rst && cyc >= idle_from && (m0_req || m1_req)) begin
      w = (m0_req && m1_req) ? !last : m1_req;
      acc = cyc + 1; own = w; last = w;
      rd = !(w ? m1_we : m0_we);
      m_addr = w ? m1_addr : m0_addr;
      m_wdata = w ? m1_wdata : m0_wdata;
      if (rd) exp_rd = mmem[m_addr[7:0]];
      else mmem[m_addr[7:0]] = m_wdata;
      idle_from = rd ? acc + L + 1 : acc + 1;
    end
    @(negedge clk);
    cyc++;
    check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    #1 check();
    @(negedge clk);
    cyc++;
    check();
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();
    // loader writes 0xDEADBEEF to 0x10, then m0 reads it back
    m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF;
    tick(); chk1("ld_gnt", m1_gnt, 1'b1);
    m1_req = 0; tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    tick(); chk1("rd_gnt", m0_gnt, 1'b1); chk1("rd_m1_gnt", m1_gnt, 1'b0);
    m0_req = 0; tick();
    chk1("rd_rvalid", m0_rvalid, 1'b1); chk("rd_data", rdata, 32'hDEADBEEF);
    chk1("rd_m1_rvalid", m1_rvalid, 1'b0);
    tick(); chk1("rd_idle", busy, 1'b0);
    // tie after reset: m0 first, m1 two cycles later, next tie m0 again
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h11111111;
    m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'h22222222;
    tick(); chk1("tie_m0", m0_gnt, 1'b1); chk1("tie_m1_held", m1_gnt, 1'b0);
    m0_req = 0; tick(); chk1("tie_gap", m1_gnt, 1'b0);
    tick(); chk1("tie_m1", m1_gnt, 1'b1);
    m1_req = 0; tick();
    m0_req = 1; m1_req = 1; m0_wdata = 32'h33333333; m1_wdata = 32'h44444444;
    tick(); chk1("tie2_m0", m0_gnt, 1'b1);
    m0_req = 0; tick(); tick(); chk1("tie2_m1", m1_gnt, 1'b1);
    m1_req = 0; tick();
    // address change during ACCESS is ignored
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    tick(); chk("acc_addr", mem_addr, 32'h20);
    m0_addr = 32'h24; m0_req = 0;
    #1 chk("acc_addr_hold", mem_addr, 32'h20);
    tick(); chk("acc_rdata", rdata, 32'h33333333);
    tick();
    // reset in ACCESS drops mem_en at once and never returns data
    m1_req = 1; m1_we = 0; m1_addr = 32'h30;
    tick(); chk1("abort_gnt", m1_gnt, 1'b1);
    m1_req = 0;
    do_reset();
    chk1("abort_mem_en", mem_en, 1'b0);
    tick(); tick();
    // RD_LAT=3: m1 read, m0 raised two cycles in
    m1_req3 = 1; m1_we3 = 0; m1_addr3 = 32'h40;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk1("l3_m1_gnt", m1_gnt3, k == 1);
      chk1("l3_m1_rvalid", m1_rvalid3, k == 4);
      chk1("l3_m0_gnt", m0_gnt3, k == 6);
      chk1("l3_m0_rvalid", m0_rvalid3, k == 9);
      chk1("l3_busy", busy3, (k >= 1 && k <= 4) || (k >= 6 && k <= 9));
      chk("l3_rdata", rdata3, (k == 4 || k == 9) ? mem_rdata3 : 32'h0);
      if (k == 1) m1_req3 = 0;
      if (k == 2) begin m0_req3 = 1; m0_we3 = 0; m0_addr3 = 32'h44; end
      if (k == 6) m0_req3 = 0;
    end
    // reset during WAIT of an m0 read
    m0_req3 = 1; m0_we3 = 0; m0_addr3 = 32'h48;
    @(negedge clk); chk1("w_gnt", m0_gnt3, 1'b1);
    m0_req3 = 0;
    @(negedge clk); chk1("w_busy", busy3, 1'b1);
    rst = 1'b1;
    #1 chk1("w_mem_en", mem_en3, 1'b0); chk1("w_busy_rst", busy3, 1'b0);
    chk1("w_rvalid_rst", m0_rvalid3, 1'b0); chk("w_rdata_rst", rdata3, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("w_no_rvalid", m0_rvalid3, 1'b0); chk1("w_idle", busy3, 1'b0);
    end
    rst = 1'b0;
    m1_req3 = 1; m1_we3 = 1; m1_addr3 = 32'h50; m1_wdata3 = 32'h55;
    @(negedge clk);
    chk1("w_m1_gnt", m1_gnt3, 1'b1); chk1("w_m1_we", mem_we3, 1'b1);
    chk("w_m1_addr", mem_addr3, 32'h50);
    m1_req3 = 0;
    @(negedge clk);
    chk1("w_m1_done", busy3, 1'b0); chk1("w_m1_en_off", mem_en3, 1'b0);
    // random traffic against the model
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      if (!m0_req || (cyc == acc && !own)) begin
        m0_req = $urandom_range(0, 2) == 0; m0_we = 1'($urandom_range(0, 1));
        m0_addr = 32'($urandom_range(0, 255)); m0_wdata = $urandom;
      end
      if (!m1_req || (cyc == acc && own)) begin
        m1_req = $urandom_range(0, 2) == 0; m1_we = 1'($urandom_range(0, 1));
        m1_addr = 32'($urandom_range(0, 255)); m1_wdata = $urandom;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter RD_LAT, default 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
REQ-004 clk  input  1  single clock; all state SHALL change on the posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 m0_req, m1_req  input  1 each  access request (m0 = CPU datapath, m1 = program loader).
REQ-007 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-008 m0_addr, m1_addr  input  AW each  byte address.
REQ-009 m0_wdata, m1_wdata  input  DW each  write data.
REQ-010 m0_gnt, m1_gnt  output  1 each  one-cycle pulse: request accepted and issued to memory.
REQ-011 m0_rvalid, m1_rvalid  output  1 each  one-cycle pulse: rdata is valid for this port.
REQ-012 rdata  output  DW  read data shared by both ports, qualified by mN_rvalid.
REQ-013 mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-014 mem_addr, mem_wdata  output  AW, DW  memory address and write data.
REQ-015 mem_rdata  input  DW  memory read data, valid RD_LAT cycles after mem_en.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and WAIT.
REQ-018 IDLE with any request SHALL select an owner, latch the owner's we/addr/wdata into internal registers, and move to ACCESS on the next edge.
REQ-019 IDLE arbitration: a single requester wins; if both request, the port not granted most recently wins (round-robin).
REQ-020 The last-grant register SHALL update on entry to ACCESS.
REQ-021 ACCESS SHALL last exactly one cycle and drive mem_en=1, the latched mem_we/mem_addr/mem_wdata, and gnt=1 for the owner only.
REQ-022 From ACCESS, a write SHALL return to IDLE.
REQ-023 From ACCESS, a read SHALL enter WAIT with a 2-bit down-counter loaded with RD_LAT-1.
REQ-024 WAIT SHALL decrement the counter each cycle.
REQ-025 The cycle that is RD_LAT cycles after the ACCESS cycle SHALL pulse the owner's rvalid and drive rdata=mem_rdata combinationally.
REQ-026 The FSM SHALL return to IDLE on the edge that ends the rvalid cycle.
REQ-027 Latency: with RD_LAT=1, req sampled in IDLE at cycle T gives gnt at T+1 and rvalid at T+2; a write gives gnt at T+1 and is back in IDLE at T+2.
REQ-028 Requesters SHALL hold req, we, addr and wdata stable until gnt; the arbiter latches them at acceptance, so changes after acceptance are ignored.
REQ-029 req still high in the cycle after gnt SHALL be treated as a new request.
REQ-030 Requests arriving in ACCESS or WAIT SHALL be held off (no gnt) until the next IDLE, where round-robin applies.
REQ-031 mem_en, mem_we and all gnt/rvalid outputs SHALL be 0 outside their defined cycles.
REQ-032 mem_addr and mem_wdata SHALL hold the last latched values when idle.
REQ-033 At most one gnt and at most one rvalid SHALL be high in any cycle.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, last-grant=m1 (so m0 wins the first tie), counter=0, and latched we/addr/wdata=0.
REQ-035 During reset all outputs SHALL be 0, including rdata=0 and busy=0.
REQ-036 Reset during ACCESS or WAIT SHALL abort the access with no rvalid, and mem_en SHALL drop in the same cycle.
REQ-037 After release, the first posedge SHALL evaluate IDLE normally.

Verification
REQ-038 RD_LAT=1, m0 read of addr 0x10, mem returns 0xDEADBEEF -> m0_gnt at T+1, m0_rvalid at T+2 with rdata=0xDEADBEEF, m1 outputs stay 0.
REQ-039 After reset, m0 and m1 both request writes in the same cycle -> m0_gnt first; m1_gnt exactly 2 cycles later; a repeated tie is then won by m0 again (last grant was m1).
REQ-040 RD_LAT=3, m1 read -> m1_gnt at T+1, m1_rvalid at T+4, busy high T+1..T+4; an m0_req raised at T+2 is granted at T+6.
REQ-041 m0 changes addr from 0x20 to 0x24 in the ACCESS cycle -> mem_addr=0x20, and the change has no effect on the issued access.
REQ-042 Assert rst during WAIT of an m0 read -> m0_rvalid never pulses, mem_en=0 and busy=0 immediately; after release, a new m1 write completes normally.
REQ-043 Random req/we traffic for 10k cycles, checked against a reference model -> no double gnt/rvalid, no starvation (each held request granted within 2 accesses), and all data matches.
